// File: rtl/channel_sum_drain.sv
// Buffers completed 16-lane partial-sum vectors and drains them lane by lane
// over a valid/ready stream, applying round-half-up shift, optional ReLU and saturation.
module channel_sum_drain #(
    parameter int unsigned LANES = 16,
    parameter int unsigned IN_W  = 11,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*IN_W-1:0]  sum_in,
    input  logic                   sum_en,
    input  logic [3:0]             shift,
    input  logic                   relu_en,
    output logic [OUT_W-1:0]       out_data,
    output logic [3:0]             out_lane,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   ovf_err
);

    localparam int unsigned EXT_W  = IN_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned LANE_W = 4;

    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]       FULL_CNT  = CNT_W'(DEPTH);
    localparam logic signed [EXT_W-1:0] SAT_HI   = EXT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_LO   = EXT_W'(-(2 ** (OUT_W - 1)));

    typedef logic [LANES-1:0][IN_W-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    vec_t               mem_q [DEPTH];
    vec_t               mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [3:0]         out_lane_q, out_lane_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               ovf_err_q, ovf_err_d;

    logic               hs, pop, full, wr;

    // Rescale one lane: round-half-up arithmetic shift, optional ReLU, saturate.
    function automatic logic [OUT_W-1:0] scale_lane(input logic [IN_W-1:0] v,
                                                    input logic [3:0]      sh,
                                                    input logic            relu);
        logic signed [EXT_W-1:0] x;
        x = $signed({v[IN_W-1], v});
        if (sh != 4'd0) begin
            x = x + (EXT_W'(1) << (sh - 4'd1));
            x = x >>> sh;
        end
        if (relu && x[EXT_W-1]) begin
            x = '0;
        end
        if (x > SAT_HI) begin
            x = SAT_HI;
        end else if (x < SAT_LO) begin
            x = SAT_LO;
        end
        return OUT_W'(x);
    endfunction

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        lane_d      = lane_q;
        ovf_err_d   = ovf_err_q;
        out_data_d  = '0;
        out_lane_d  = '0;
        out_last_d  = 1'b0;

        hs   = (state_q == DRAIN) && out_ready;
        pop  = hs && (lane_q == LAST_LANE);
        full = (count_q == FULL_CNT);
        wr   = sum_en && (!full || pop);

        if (sum_en && full && !pop) begin
            ovf_err_d = 1'b1;
        end
        if (wr) begin
            mem_d[wr_ptr_q] = vec_t'(sum_in);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = DRAIN;
                    lane_d  = '0;
                end
            end
            DRAIN: begin
                if (hs) begin
                    lane_d = lane_q + LANE_W'(1);
                    if (pop) begin
                        lane_d = '0;
                        if (count_d == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-cycle view so a vector written
        // alongside a pop drains with no bubble.
        out_valid_d = (state_d == DRAIN);
        busy_d      = (count_d != '0) || (state_d == DRAIN);
        if (state_d == DRAIN) begin
            out_data_d = scale_lane(mem_d[rd_ptr_d][lane_d], shift, relu_en);
            out_lane_d = lane_d;
            out_last_d = (lane_d == LAST_LANE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_channel_sum_drain.sv
// Scoreboard bench for channel_sum_drain: expected beats are queued as vectors
// are sent and compared as the DUT hands them out.
module tb_channel_sum_drain;

    localparam int LANES = 16;
    localparam int IN_W  = 11;
    localparam int OUT_W = 8;

    logic                  clk;
    logic                  rst;
    logic [LANES*IN_W-1:0] sum_in;
    logic                  sum_en;
    logic [3:0]            shift;
    logic                  relu_en;
    logic [OUT_W-1:0]      out_data;
    logic [3:0]            out_lane;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  ovf_err;

    channel_sum_drain dut (
        .clk       (clk),
        .rst       (rst),
        .sum_in    (sum_in),
        .sum_en    (sum_en),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int lane;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   beats    = 0;
    bit   mon_en   = 1'b0;
    bit   hold_vld = 1'b0;
    int   hold_data, hold_lane, hold_last;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic int ref_lane(input int v, input int sh, input bit relu);
        int r;
        r = v;
        if (sh > 0) r = (r + (1 << (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a[LANES], input int e[LANES], input bit push);
        for (int k = 0; k < LANES; k++) begin
            sum_in[k*IN_W +: IN_W] = IN_W'(a[k]);
        end
        sum_en = 1'b1;
        if (push) begin
            for (int k = 0; k < LANES; k++) begin
                exp_q.push_back('{data: e[k], lane: k, last: (k == LANES - 1) ? 1 : 0});
            end
        end
        tick();
        sum_en = 1'b0;
    endtask

    task automatic model_exp(input int a[LANES], output int e[LANES]);
        for (int k = 0; k < LANES; k++) e[k] = ref_lane(a[k], int'(shift), relu_en);
    endtask

    task automatic rand_vec(output int a[LANES]);
        for (int k = 0; k < LANES; k++) a[k] = int'($urandom_range(0, 2047)) - 1024;
    endtask

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            tick();
            n++;
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
    endtask

    // Beat monitor: handshake seen at the falling edge completes on the next rise.
    always @(negedge clk) begin
        if (!rst) begin
            hold_vld <= 1'b0;
        end else if (mon_en) begin
            if (hold_vld && out_valid) begin
                check_eq("hold_data", int'($signed(out_data)), hold_data);
                check_eq("hold_lane", int'(out_lane), hold_lane);
                check_eq("hold_last", int'(out_last), hold_last);
            end
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("data", int'($signed(out_data)), e.data);
                    check_eq("lane", int'(out_lane), e.lane);
                    check_eq("last", int'(out_last), e.last);
                end
            end
            hold_vld  <= out_valid && !out_ready;
            hold_data <= int'($signed(out_data));
            hold_lane <= int'(out_lane);
            hold_last <= int'(out_last);
        end
    end

    initial begin
        int a[LANES];
        int e[LANES];
        int b[LANES];
        int eb[LANES];
        int n;
        int beats0;

        rst       = 1'b0;
        sum_in    = '0;
        sum_en    = 1'b0;
        shift     = 4'd0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_ovf", int'(ovf_err), 0);
        check_eq("rst_data", int'(out_data), 0);
        check_eq("rst_lane", int'(out_lane), 0);
        rst    = 1'b1;
        mon_en = 1'b1;
        tick();

        // Basic rounding and two-cycle latency.
        shift = 4'd1; relu_en = 1'b0;
        a = '{default: 0}; a[0] = 5; a[1] = -5; a[2] = 0; a[3] = 1;
        e = '{default: 0}; e[0] = 3; e[1] = -2; e[2] = 0; e[3] = 1;
        send(a, e, 1'b1);
        check_eq("lat_t1_valid", int'(out_valid), 0);
        tick();
        check_eq("lat_t2_valid", int'(out_valid), 1);
        check_eq("lat_t2_lane", int'(out_lane), 0);
        wait_drained("basic");

        // Saturation with shift 2, then pass-through with shift 0.
        shift = 4'd2;
        a = '{default: 0}; a[0] = 1023; a[1] = -1024;
        e = '{default: 0}; e[0] = 127; e[1] = -128;
        send(a, e, 1'b1);
        wait_drained("sat2");
        shift = 4'd0;
        a = '{default: 0}; a[2] = 100; a[3] = -200;
        e = '{default: 0}; e[2] = 100; e[3] = -128;
        send(a, e, 1'b1);
        wait_drained("sat0");

        // ReLU.
        shift = 4'd1; relu_en = 1'b1;
        a = '{default: 0}; a[0] = -5; a[1] = 7;
        e = '{default: 0}; e[0] = 0; e[1] = 4;
        send(a, e, 1'b1);
        wait_drained("relu");

        // Backpressure with ready pattern 1,0,0,1.
        shift = 4'd3; relu_en = 1'b0;
        rand_vec(a); model_exp(a, e);
        send(a, e, 1'b1);
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            out_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        out_ready = 1'b1;
        wait_drained("bp");

        // Write coincident with the last-lane pop while full: accepted, no overflow.
        shift = 4'd4; relu_en = 1'b1;
        out_ready = 1'b0;
        rand_vec(a); model_exp(a, e); send(a, e, 1'b1);
        rand_vec(a); model_exp(a, e); send(a, e, 1'b1);
        tick();
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_lane == 4'd15) && n < 100) begin
            tick();
            n++;
        end
        check_eq("lane15_seen", int'(out_valid && out_lane == 4'd15), 1);
        rand_vec(b); model_exp(b, eb); send(b, eb, 1'b1);
        check_eq("coinc_ovf", int'(ovf_err), 0);
        wait_drained("coinc");
        check_eq("coinc_ovf_end", int'(ovf_err), 0);

        // Overflow: third vector dropped, then 32 beats with no bubble.
        shift = 4'd2; relu_en = 1'b0;
        out_ready = 1'b0;
        rand_vec(a); model_exp(a, e); send(a, e, 1'b1);
        rand_vec(a); model_exp(a, e); send(a, e, 1'b1);
        rand_vec(a); model_exp(a, e); send(a, e, 1'b0);
        tick();
        check_eq("ovf_set", int'(ovf_err), 1);
        check_eq("ovf_busy", int'(busy), 1);
        beats0    = beats;
        out_ready = 1'b1;
        repeat (32) tick();
        check_eq("ovf_beats", beats - beats0, 32);
        wait_drained("ovf");
        check_eq("ovf_sticky", int'(ovf_err), 1);

        // Reset in the middle of a drain.
        shift = 4'd1; relu_en = 1'b0;
        rand_vec(a); model_exp(a, e); send(a, e, 1'b1);
        n = 0;
        while (!(out_valid && out_lane == 4'd7) && n < 100) begin
            tick();
            n++;
        end
        check_eq("lane7_seen", int'(out_valid && out_lane == 4'd7), 1);
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_eq("mid_rst_valid", int'(out_valid), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_ovf", int'(ovf_err), 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        rand_vec(a); model_exp(a, e); send(a, e, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("post_rst_lane", int'(out_lane), 0);
        check_eq("post_rst_valid", int'(out_valid), 1);
        wait_drained("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
